// File: rtl/inst_mem_pipe.sv
// Byte-organised instruction memory with a one-cycle fetch stage, a load port and freeze stall.
// Define INST_MEM_NOP_INIT_EN to add a post-reset sweep that fills every word with NOP.

module inst_mem_lane #(
  parameter int WORD_LEN = 8,
  parameter int DEPTH    = 512,
  parameter int AW       = 9
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [WORD_LEN-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [WORD_LEN-1:0] rdata
);
  logic [WORD_LEN-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Asynchronous read so the response register samples the pre-write contents.
  assign rdata = mem[raddr];
endmodule

module inst_mem_pipe #(
  parameter int                  WORD_LEN = 8,
  parameter int                  MEM_SIZE = 2048,
  parameter int                  INST_LEN = 32,
  parameter logic [INST_LEN-1:0] NOP      = 32'hE000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [INST_LEN-1:0] req_addr,
  output logic                req_ready,
  input  logic                freeze,
  output logic                rsp_valid,
  output logic [INST_LEN-1:0] rsp_inst,
  output logic                rsp_err,
  input  logic                load_en,
  input  logic [INST_LEN-1:0] load_addr,
  input  logic [INST_LEN-1:0] load_data,
  output logic                busy
);
  localparam int NUM_LANES = INST_LEN / WORD_LEN;
  localparam int DEPTH     = MEM_SIZE / 4;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INST_LEN-1:0] LAST_ADDR = INST_LEN'(MEM_SIZE - 4);

  logic                                req_ok, load_ok, accept;
  logic                                fill_we, we;
  logic [AW-1:0]                       fill_cnt, waddr;
  logic [INST_LEN-1:0]                 wdata;
  logic [NUM_LANES-1:0][WORD_LEN-1:0]  wlanes, rlanes;

  assign req_ready = !busy && !freeze;
  assign accept    = req_valid && req_ready;
  assign req_ok    = (req_addr[1:0] == 2'b00) && (req_addr <= LAST_ADDR);
  assign load_ok   = load_en && !busy && (load_addr[1:0] == 2'b00) && (load_addr <= LAST_ADDR);

`ifdef INST_MEM_NOP_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      fill_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= (state == INIT && state_nxt == INIT) ? fill_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    fill_we   = 1'b0;
    case (state)
      INIT: begin
        busy    = 1'b1;
        fill_we = 1'b1;
        if (fill_cnt == AW'(DEPTH - 1)) state_nxt = RUN;
      end
      default: ;
    endcase
  end
`else
  assign busy     = 1'b0;
  assign fill_we  = 1'b0;
  assign fill_cnt = '0;
`endif

  // Reset discards both the sweep write and any load presented on that edge.
  assign we     = !rst && (fill_we || load_ok);
  assign waddr  = fill_we ? fill_cnt : load_addr[AW+1:2];
  assign wdata  = fill_we ? NOP : load_data;
  assign wlanes = wdata;

  // Lane NUM_LANES-1 holds the lowest byte address (big-endian word).
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    inst_mem_lane #(.WORD_LEN(WORD_LEN), .DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wlanes[l]),
      .raddr (req_addr[AW+1:2]),
      .rdata (rlanes[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_inst  <= NOP;
      rsp_err   <= 1'b0;
    end else if (!freeze) begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_inst <= req_ok ? INST_LEN'(rlanes) : NOP;
        rsp_err  <= !req_ok;
      end
    end
  end
endmodule

// File: tb/tb_inst_mem_pipe.sv
// Directed plus randomized bench for inst_mem_pipe against a byte-array reference model.
// Honours INST_MEM_NOP_INIT_EN so either build of the design can be exercised.

module tb_inst_mem_pipe;
  localparam int MEM_SIZE = 64;
  localparam int DEPTH    = MEM_SIZE / 4;
  localparam logic [31:0] NOP = 32'hE000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, freeze = 1'b0, load_en = 1'b0;
  logic [31:0] req_addr = '0, load_addr = '0, load_data = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_inst;

  inst_mem_pipe #(.WORD_LEN(8), .MEM_SIZE(MEM_SIZE), .INST_LEN(32), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .freeze(freeze), .rsp_valid(rsp_valid), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [7:0]  mm [MEM_SIZE];
  logic        exp_v;
  logic [31:0] exp_i;
  logic        exp_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(MEM_SIZE - 4));
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {mm[a], mm[a+1], mm[a+2], mm[a+3]};
  endfunction

  task automatic check_rsp(input string tag);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(exp_v));
    chk({tag, ".inst"},  rsp_inst, exp_i);
    chk({tag, ".err"},   32'(rsp_err), 32'(exp_e));
  endtask

  // One clock with the given inputs; the model predicts the response from pre-edge contents.
  task automatic cycle(input string tag, input logic v, input logic [31:0] a, input logic f,
                       input logic le, input logic [31:0] la, input logic [31:0] ld);
    req_valid = v; req_addr = a; freeze = f; load_en = le; load_addr = la; load_data = ld;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(!f));
    chk({tag, ".busy"},  32'(busy), 32'd0);
    if (!f) begin
      exp_v = v;
      if (v) begin
        exp_i = in_range(a) ? mword(a) : NOP;
        exp_e = !in_range(a);
      end
    end
    @(posedge clk); #1;
    if (le && in_range(la)) {mm[la], mm[la+1], mm[la+2], mm[la+3]} = ld;
    check_rsp(tag);
    req_valid = 1'b0; load_en = 1'b0; freeze = 1'b0;
  endtask

  task automatic pulse_rst(input int hold);
    rst = 1'b1; req_valid = 1'b0; load_en = 1'b0; freeze = 1'b0;
    repeat (hold) @(posedge clk);
    #1; rst = 1'b0;
    exp_v = 1'b0; exp_i = NOP; exp_e = 1'b0;
    check_rsp("reset");
  endtask

  task automatic wait_fill();
    int n = 0;
    chk("busy_after_rst", 32'(busy), 32'd1);
    chk("ready_during_busy", 32'(req_ready), 32'd0);
    while (busy && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("busy_cycles", n, DEPTH);
    for (int i = 0; i < MEM_SIZE; i += 4) {mm[i], mm[i+1], mm[i+2], mm[i+3]} = NOP;
  endtask

  task automatic do_reset();
    pulse_rst(2);
`ifdef INST_MEM_NOP_INIT_EN
    wait_fill();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, la, ld;
    logic        v, f, le;
    do_reset();

`ifdef INST_MEM_NOP_INIT_EN
    // Loads during the sweep vanish; a reset part-way through restarts the full sweep.
    load_en = 1'b1; load_addr = 32'h0; load_data = 32'h1234_5678;
    repeat (8) @(posedge clk);
    pulse_rst(1);
    load_en = 1'b0;
    wait_fill();
    for (int i = 0; i < DEPTH; i++) cycle("nopfill", 1'b1, 32'(i * 4), 1'b0, 1'b0, '0, '0);
`endif

    for (int i = 0; i < DEPTH; i++) cycle("preload", 1'b0, '0, 1'b0, 1'b1, 32'(i * 4), $urandom);

    cycle("ld0", 1'b0, '0, 1'b0, 1'b1, 32'h0, 32'hE3A0_0014);
    cycle("fetch0", 1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("fetch0.byte0", 32'(rsp_inst[31:24]), 32'hE3);
    cycle("misalign", 1'b1, 32'h6, 1'b0, 1'b0, '0, '0);
    cycle("oor", 1'b1, 32'(MEM_SIZE), 1'b0, 1'b0, '0, '0);
    cycle("last", 1'b1, 32'(MEM_SIZE - 4), 1'b0, 1'b0, '0, '0);

    cycle("frz_acc", 1'b1, 32'h0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) cycle("frz_hold", 1'b1, 32'h4, 1'b1, 1'b0, '0, '0);
    cycle("frz_idle", 1'b0, '0, 1'b0, 1'b0, '0, '0);

    cycle("ld8", 1'b0, '0, 1'b0, 1'b1, 32'h8, 32'h2222_2222);
    cycle("rbw", 1'b1, 32'h8, 1'b0, 1'b1, 32'h8, 32'h1111_1111);
    chk("rbw.old", rsp_inst, 32'h2222_2222);
    cycle("rbw_re", 1'b1, 32'h8, 1'b0, 1'b0, '0, '0);
    chk("rbw.new", rsp_inst, 32'h1111_1111);

    // Loads held during freeze still land; bad load addresses are ignored.
    cycle("frz_ld", 1'b0, '0, 1'b1, 1'b1, 32'hC, 32'hA5A5_0F0F);
    cycle("bad_ld", 1'b0, '0, 1'b0, 1'b1, 32'hD, 32'hDEAD_BEEF);
    cycle("chk_c", 1'b1, 32'hC, 1'b0, 1'b0, '0, '0);

    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 9))
        6:       a = 32'($urandom_range(0, MEM_SIZE - 1)) | 32'h1;
        7:       a = 32'(MEM_SIZE - 4);
        8:       a = 32'(MEM_SIZE);
        9:       a = $urandom;
        default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
      le = ($urandom_range(0, 2) == 0);
      la = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1) * 4);
      if ($urandom_range(0, 3) == 0) la = a;
      ld = $urandom;
      cycle("rand", v, a, f, le, la, ld);
    end

    cycle("keep_ld", 1'b0, '0, 1'b0, 1'b1, 32'h4, 32'h5A5A_C3C3);
    do_reset();
    cycle("keep_fetch", 1'b1, 32'h4, 1'b0, 1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_mem_pipe.md
INST_MEM_PIPE -- requirements
Module: inst_mem_pipe

Interface
REQ-001 Parameter WORD_LEN, default 8: bits per memory location (byte).
REQ-002 Parameter MEM_SIZE, default 2048: number of byte locations; a multiple of 4.
REQ-003 Parameter INST_LEN, default 32: instruction and address width.
REQ-004 Parameter NOP, default 32'hE000_0000: instruction returned for invalid fetches and used as fill value.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 req_valid  input  1  fetch request present.
REQ-008 req_addr  input  INST_LEN  byte address of fetch.
REQ-009 req_ready  output  1  fetch request can be accepted this cycle.
REQ-010 freeze  input  1  pipeline stall; holds response stage.
REQ-011 rsp_valid  output  1  rsp_inst/rsp_err hold a fetch result.
REQ-012 rsp_inst  output  INST_LEN  fetched instruction.
REQ-013 rsp_err  output  1  fetch was misaligned or out of range.
REQ-014 load_en  input  1  write one instruction word into memory.
REQ-015 load_addr  input  INST_LEN  byte address of load word.
REQ-016 load_data  input  INST_LEN  word to store.
REQ-017 busy  output  1  memory initialisation in progress.

Function
REQ-018 Word at byte address A SHALL be {mem[A], mem[A+1], mem[A+2], mem[A+3]}, big-endian (mem[A] = bits [31:24]).
REQ-019 req_ready SHALL equal !busy && !freeze, combinationally.
REQ-020 Accepted fetch (req_valid && req_ready) SHALL present rsp_valid=1 and its result on the next rising edge (latency 1).
REQ-021 Cycle with no accepted fetch and freeze=0 SHALL clear rsp_valid on next edge; rsp_inst/rsp_err keep last value.
REQ-022 freeze=1 SHALL hold rsp_valid, rsp_inst, rsp_err unchanged.
REQ-023 req_addr[1:0] != 0 SHALL return rsp_inst=NOP, rsp_err=1.
REQ-024 req_addr > MEM_SIZE-4 SHALL return rsp_inst=NOP, rsp_err=1; no wrap-around.
REQ-025 Valid fetch SHALL return stored word with rsp_err=0.
REQ-026 load_en=1 with busy=0, aligned, in-range load_addr SHALL write load_data (REQ-018 order) on that edge; other loads SHALL be silently dropped.
REQ-027 Load and fetch to same address in same cycle SHALL return the pre-write word (read-before-write).
REQ-028 load_en SHALL be accepted regardless of freeze.
REQ-029 State machine: INIT (fill sweep, busy=1) and RUN (busy=0); INIT->RUN after last word written; RUN->INIT only on rst.

Reset
REQ-030 rst=1 at an edge SHALL set rsp_valid=0, rsp_inst=NOP, rsp_err=0, fill counter=0.
REQ-031 rst SHALL discard any in-flight fetch and pending load; rst mid-sweep restarts sweep at word 0.
REQ-032 rst SHALL enter INIT if INST_MEM_NOP_INIT_EN defined, else RUN.

Configuration
REQ-033 Macro INST_MEM_NOP_INIT_EN defined: after reset, INIT writes NOP to one word per cycle, words 0..MEM_SIZE/4-1, busy=1 for exactly MEM_SIZE/4 cycles, fetches and loads blocked.
REQ-034 Macro absent: no INIT state, busy tied 0, memory content not altered by reset; fetch ready on first cycle after reset.

Verification
REQ-035 Load 0xE3A00014 at 0, fetch 0 -> next cycle rsp_valid=1, rsp_inst=0xE3A00014, rsp_err=0; mem[0]=0xE3.
REQ-036 Fetch addr 0x6 -> rsp_inst=0xE0000000, rsp_err=1; fetch addr MEM_SIZE -> same.
REQ-037 Fetch accepted, freeze=1 for 3 cycles with new req_valid -> req_ready=0, response held 3 cycles, no new fetch accepted.
REQ-038 Same-cycle load 0x11111111 and fetch at 8 (old 0x22222222) -> rsp_inst=0x22222222; refetch -> 0x11111111.
REQ-039 With INST_MEM_NOP_INIT_EN, MEM_SIZE=64: busy=1 for 16 cycles after rst, load during busy dropped, all fetches then return 0xE0000000 with rsp_err=0; rst asserted at cycle 8 restarts full 16-cycle sweep.
REQ-040 Without macro: load word at 4, pulse rst, fetch 4 -> previously loaded word returned, busy never 1.
